// File: rtl/pending_encoder_64_6_if.sv
// Request/offer bundle between event sources, the pending encoder and its consumer.
// The slave modport is the encoder side; the master modport drives requests and ready.
interface pending_encoder_64_6_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDX_W = 6
);
   logic [WIDTH-1:0] set_vec;
   logic [WIDTH-1:0] clr_vec;
   logic             out_ready;
   logic             out_valid;
   logic [IDX_W-1:0] out_idx;
   logic [WIDTH-1:0] out_onehot;
   logic [WIDTH-1:0] pending;
   logic             any_pend;

   modport master (
      output set_vec, clr_vec, out_ready,
      input  out_valid, out_idx, out_onehot, pending, any_pend
   );

   modport slave (
      input  set_vec, clr_vec, out_ready,
      output out_valid, out_idx, out_onehot, pending, any_pend
   );
endinterface

// File: rtl/pending_encoder_64_6.sv
// Collects request bits into a pending register and offers the lowest-numbered
// pending bit as a binary index over valid/ready; the bit is retired on acceptance.
module pending_encoder_64_6 #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDX_W = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   pending_encoder_64_6_if.slave  bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] onehot_q, onehot_d;
   logic [IDX_W-1:0] enc;
   logic             handshake;
   logic [WIDTH-1:0] retire;

   // Fixed-priority encoder on the registered pending value; bit 0 wins.
   always_comb begin
      enc = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            enc = IDX_W'(i);
         end
      end
   end

   assign handshake = valid_q & bus.out_ready;
   assign retire    = handshake ? onehot_q : '0;

   // Set beats clear beats retire, bit by bit.
   assign pend_d = (pend_q & ~bus.clr_vec & ~retire) | bus.set_vec;

   // Next-state and offer registers; IDLE is a forced one-cycle bubble after each grant.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      unique case (state_q)
         IDLE: begin
            valid_d  = 1'b0;
            onehot_d = '0;
            if (|pend_q) begin
               idx_d    = enc;
               onehot_d = WIDTH'(1) << enc;
               valid_d  = 1'b1;
               state_d  = OFFER;
            end
         end
         OFFER: begin
            valid_d = 1'b1;
            if (bus.out_ready) begin
               valid_d  = 1'b0;
               onehot_d = '0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
      end
   end

   assign bus.pending    = pend_q;
   assign bus.any_pend   = |pend_q;
   assign bus.out_valid  = valid_q;
   assign bus.out_idx    = idx_q;
   assign bus.out_onehot = onehot_q;

endmodule

// File: tb/tb_pending_encoder_64_6.sv
// Directed scenarios plus randomized traffic for pending_encoder_64_6, checked
// cycle by cycle against a behavioural model of the pending set and the offer.
module tb_pending_encoder_64_6;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   pending_encoder_64_6_if #(.WIDTH(64), .IDX_W(6)) bus ();

   pending_encoder_64_6 #(.WIDTH(64), .IDX_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [63:0] m_pend;
   bit          m_valid;
   int          m_idx;

   function automatic int lowest(input logic [63:0] v);
      for (int i = 0; i < 64; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock: model consumes the inputs present at the edge.
   task automatic step(input string tag);
      logic [63:0] s, c, nxt;
      bit          r, rdy, hs;
      logic [63:0] one;
      s   = bus.set_vec;
      c   = bus.clr_vec;
      r   = reset;
      rdy = bus.out_ready;
      @(posedge clk);
      #1;
      if (r) begin
         m_pend  = '0;
         m_valid = 0;
         m_idx   = 0;
      end else begin
         hs  = m_valid && rdy;
         nxt = m_pend;
         for (int i = 0; i < 64; i++) begin
            if (s[i])                    nxt[i] = 1'b1;
            else if (c[i])               nxt[i] = 1'b0;
            else if (hs && i == m_idx)   nxt[i] = 1'b0;
         end
         if (m_valid) begin
            if (rdy) m_valid = 0;
         end else if (m_pend != 0) begin
            m_idx   = lowest(m_pend);
            m_valid = 1;
         end
         m_pend = nxt;
      end
      one = 64'd1;
      check({tag, ".valid"},  64'(bus.out_valid), 64'(m_valid));
      check({tag, ".idx"},    64'(bus.out_idx), 64'(m_idx));
      check({tag, ".onehot"}, bus.out_onehot, m_valid ? (one << m_idx) : 64'd0);
      check({tag, ".pend"},   bus.pending, m_pend);
      check({tag, ".any"},    64'(bus.any_pend), 64'(m_pend != 0));
   endtask

   task automatic drive(input logic [63:0] s, input logic [63:0] c, input bit rdy);
      bus.set_vec   = s;
      bus.clr_vec   = c;
      bus.out_ready = rdy;
   endtask

   initial begin
      logic [63:0] r_s, r_c;
      int          t2_idx [3];
      t2_idx = '{0, 7, 63};

      reset = 1'b1;
      drive('0, '0, 1'b0);
      step("rst");
      check("rst.valid_c",  64'(bus.out_valid), 64'd0);
      check("rst.pend_c",   bus.pending, 64'd0);
      check("rst.onehot_c", bus.out_onehot, 64'd0);
      reset = 1'b0;

      // T1: single request, two-cycle latency then retire
      drive(64'h10, '0, 1'b1);
      step("t1a");
      check("t1.valid_early", 64'(bus.out_valid), 64'd0);
      drive('0, '0, 1'b1);
      step("t1b");
      check("t1.valid",  64'(bus.out_valid), 64'd1);
      check("t1.idx",    64'(bus.out_idx), 64'd4);
      check("t1.onehot", bus.out_onehot, 64'h10);
      step("t1c");
      check("t1.pend_empty", bus.pending, 64'd0);
      check("t1.valid_off",  64'(bus.out_valid), 64'd0);

      // T2: three requests granted every second cycle, lowest first
      drive(64'h8000_0000_0000_0081, '0, 1'b1);
      step("t2set");
      drive('0, '0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step("t2g");
         check("t2.valid", 64'(bus.out_valid), 64'd1);
         check("t2.idx",   64'(bus.out_idx), 64'(t2_idx[k]));
         step("t2b");
         check("t2.bubble", 64'(bus.out_valid), 64'd0);
      end
      check("t2.empty", bus.pending, 64'd0);

      // T3: a lower index arriving mid-offer does not preempt
      drive(64'h20, '0, 1'b0);
      step("t3a");
      drive('0, '0, 1'b0);
      step("t3b");
      check("t3.idx5", 64'(bus.out_idx), 64'd5);
      drive(64'h4, '0, 1'b0);
      step("t3c");
      drive('0, '0, 1'b0);
      step("t3d");
      check("t3.hold_idx", 64'(bus.out_idx), 64'd5);
      check("t3.hold_pend", bus.pending, 64'h24);
      drive('0, '0, 1'b1);
      step("t3e");
      check("t3.bubble", 64'(bus.out_valid), 64'd0);
      step("t3f");
      check("t3.idx2", 64'(bus.out_idx), 64'd2);
      step("t3g");

      // T4: set beats clear; re-set during handshake keeps the bit
      drive(64'h8, 64'h8, 1'b0);
      step("t4a");
      check("t4.set_wins", bus.pending, 64'h8);
      drive('0, '0, 1'b0);
      step("t4b");
      drive(64'h8, '0, 1'b1);
      step("t4c");
      check("t4.reset_keep", bus.pending, 64'h8);
      drive('0, '0, 1'b0);
      step("t4d");
      check("t4.reoffer", 64'(bus.out_idx), 64'd3);
      drive('0, '0, 1'b1);
      step("t4e");
      drive('0, '0, 1'b0);

      // T5: clearing the offered bit leaves the offer standing
      drive(64'h200, '0, 1'b0);
      step("t5a");
      drive('0, '0, 1'b0);
      step("t5b");
      drive('0, 64'h200, 1'b0);
      step("t5c");
      check("t5.pend_cleared", bus.pending, 64'd0);
      check("t5.still_valid",  64'(bus.out_valid), 64'd1);
      drive('0, '0, 1'b1);
      step("t5d");
      check("t5.any_off", 64'(bus.any_pend), 64'd0);
      drive('0, '0, 1'b0);
      step("t5e");
      check("t5.idle", 64'(bus.out_valid), 64'd0);

      // T6: reset during an offer discards that cycle's set_vec
      drive(64'hFF, '0, 1'b0);
      step("t6a");
      drive('0, '0, 1'b0);
      step("t6b");
      reset = 1'b1;
      drive(64'h100, '0, 1'b0);
      step("t6c");
      check("t6.pend", bus.pending, 64'd0);
      check("t6.valid", 64'(bus.out_valid), 64'd0);
      reset = 1'b0;
      drive('0, '0, 1'b0);
      step("t6d");
      check("t6.discard", bus.pending, 64'd0);

      // Randomized sparse traffic
      for (int n = 0; n < 600; n++) begin
         r_s = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
         r_c = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
         if ($urandom_range(3) != 0) r_s = '0;
         if ($urandom_range(3) != 0) r_c = '0;
         reset = ($urandom_range(63) == 0);
         drive(r_s, r_c, 1'($urandom_range(1)));
         step("rnd");
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
